// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared port encoding, flit field extraction and XY routing for mesh_router
package router_pkg;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    localparam int NUM_PORTS = 5;

    // Destination X sits in the top x_w bits of the flit.
    function automatic logic [31:0] dest_x(input logic [63:0] flit, input int data_w, input int x_w);
        logic [63:0] s;
        s = flit >> (data_w - x_w);
        return s[31:0] & ((32'd1 << x_w) - 32'd1);
    endfunction

    function automatic logic [31:0] dest_y(input logic [63:0] flit, input int data_w, input int x_w,
                                           input int y_w);
        logic [63:0] s;
        s = flit >> (data_w - x_w - y_w);
        return s[31:0] & ((32'd1 << y_w) - 32'd1);
    endfunction

    // X is resolved fully before Y, which keeps the mesh deadlock-free.
    function automatic port_e xy_route(input logic [31:0] dx, input logic [31:0] dy,
                                       input logic [31:0] mx, input logic [31:0] my);
        if (dx > mx)      return PORT_E;
        else if (dx < mx) return PORT_W;
        else if (dy > my) return PORT_N;
        else if (dy < my) return PORT_S;
        else              return PORT_L;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - circular-buffer input FIFO with count register for one router port
module flit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
        if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/mesh_router.sv
// rtl/mesh_router.sv - 5-port XY mesh router with per-output round-robin and credit flow control
module mesh_router
    import router_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 4,
    parameter int DOWN_DEPTH = 4,
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    data_i [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] valid_i,
    output logic [NUM_PORTS-1:0] incr_o,
    output logic [DATA_W-1:0]    data_o [NUM_PORTS],
    output logic [NUM_PORTS-1:0] valid_o,
    input  logic [NUM_PORTS-1:0] incr_i,
    output logic [NUM_PORTS-1:0] err_o
);
    localparam int CRED_W = $clog2(DOWN_DEPTH + 1);

    logic [DATA_W-1:0]    head [NUM_PORTS];
    port_e                route [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty, full, wr_en, pop, ovf, cred_err;
    logic [NUM_PORTS-1:0] incr_q, incr_d, err_q, err_d;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        // A full FIFO still accepts a flit when its head leaves in the same cycle.
        assign wr_en[p] = valid_i[p] && (!full[p] || pop[p]);
        assign ovf[p]   = valid_i[p] && full[p] && !pop[p];

        flit_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[p]),
            .wr_data (data_i[p]),
            .rd_en   (pop[p]),
            .head    (head[p]),
            .empty   (empty[p]),
            .full    (full[p])
        );

        assign route[p] = xy_route(dest_x(64'(head[p]), DATA_W, X_W),
                                   dest_y(64'(head[p]), DATA_W, X_W, Y_W),
                                   32'(MY_X), 32'(MY_Y));
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [CRED_W-1:0]    credit_q, credit_d;
        logic [2:0]           rr_q, rr_d, idx;
        logic [DATA_W-1:0]    data_q, data_d;
        logic                 valid_q, valid_d, cerr;
        logic [NUM_PORTS-1:0] req, g;

        always_comb begin
            req     = '0;
            g       = '0;
            rr_d    = rr_q;
            data_d  = data_q;
            valid_d = 1'b0;
            idx     = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[i] = !empty[i] && (route[i] == port_e'(o));
            end
            if (credit_q != '0) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = 3'((int'(rr_q) + k) % NUM_PORTS);
                    if (!valid_d && req[idx]) begin
                        g[idx]  = 1'b1;
                        valid_d = 1'b1;
                        data_d  = head[idx];
                        rr_d    = (idx == 3'(NUM_PORTS - 1)) ? 3'd0 : idx + 3'd1;
                    end
                end
            end
            credit_d = credit_q;
            cerr     = 1'b0;
            if (valid_d && !incr_i[o]) begin
                credit_d = credit_q - CRED_W'(1);
            end else if (!valid_d && incr_i[o]) begin
                if (credit_q == CRED_W'(DOWN_DEPTH)) cerr = 1'b1;
                else                                 credit_d = credit_q + CRED_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                credit_q <= CRED_W'(DOWN_DEPTH);
                rr_q     <= '0;
                data_q   <= '0;
                valid_q  <= 1'b0;
            end else begin
                credit_q <= credit_d;
                rr_q     <= rr_d;
                data_q   <= data_d;
                valid_q  <= valid_d;
            end
        end

        assign gnt[o]      = g;
        assign cred_err[o] = cerr;
        assign data_o[o]   = data_q;
        assign valid_o[o]  = valid_q;
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) pop = pop | gnt[o];
        incr_d = pop;
        err_d  = err_q | ovf | cred_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            incr_q <= '0;
            err_q  <= '0;
        end else begin
            incr_q <= incr_d;
            err_q  <= err_d;
        end
    end

    assign incr_o = incr_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_mesh_router.sv
// tb/tb_mesh_router.sv - scoreboard bench for mesh_router at node (1,1), DEPTH 4, DOWN_DEPTH 2
module tb_mesh_router;
    logic        clk;
    logic        rst;
    logic [15:0] data_i [5];
    logic [4:0]  valid_i;
    logic [4:0]  incr_o;
    logic [15:0] data_o [5];
    logic [4:0]  valid_o;
    logic [4:0]  incr_i;
    logic [4:0]  err_o;

    logic [4:0]  man_incr, auto_incr, auto_en;
    logic [15:0] exp_q [5][$];
    int          emit_cnt [5];
    int          incr_cnt [5];
    int          checks, failures;
    int          e0, i0;

    assign incr_i = man_incr | auto_incr;

    mesh_router #(
        .DATA_W(16), .DEPTH(4), .DOWN_DEPTH(2), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .incr_o  (incr_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .incr_i  (incr_i),
        .err_o   (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: pops the scoreboard on every emitted flit and models the downstream credit return.
    always @(negedge clk) begin
        logic [15:0] e;
        for (int o = 0; o < 5; o++) begin
            auto_incr[o] = valid_o[o] && auto_en[o] && !rst;
            if (incr_o[o]) incr_cnt[o]++;
            if (valid_o[o]) begin
                emit_cnt[o]++;
                checks++;
                if (exp_q[o].size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected port=%0d actual=%h required=none", o, data_o[o]);
                end else begin
                    e = exp_q[o].pop_front();
                    if (data_o[o] !== e) begin
                        failures++;
                        $display("FAIL sb_data port=%0d actual=%h required=%h", o, data_o[o], e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        valid_i  = '0;
        man_incr = '0;
    endtask

    task automatic put(input int p, input logic [15:0] f, input int out, input bit expect_emit);
        data_i[p]  = f;
        valid_i[p] = 1'b1;
        if (expect_emit) exp_q[out].push_back(f);
    endtask

    initial begin
        rst = 1'b1;
        valid_i = '0;
        man_incr = '0;
        auto_incr = '0;
        auto_en = 5'b11111;
        checks = 0;
        failures = 0;
        for (int p = 0; p < 5; p++) begin
            data_i[p] = '0;
            emit_cnt[p] = 0;
            incr_cnt[p] = 0;
        end
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid_o", 32'(valid_o), 32'h0);
        chk("reset_incr_o", 32'(incr_o), 32'h0);
        chk("reset_err_o", 32'(err_o), 32'h0);
        chk("reset_data_o_e", 32'(data_o[2]), 32'h0);

        // Local to east: 0xB0A5 is dest (2,3).
        put(4, 16'hB0A5, 2, 1);
        tick();
        chk("l2e_cycle1_valid", 32'(valid_o[2]), 32'h0);
        tick();
        chk("l2e_cycle2_valid", 32'(valid_o[2]), 32'h1);
        chk("l2e_cycle2_data", 32'(data_o[2]), 32'hB0A5);
        chk("l2e_incr_o", 32'(incr_o), 32'h10);
        tick();
        chk("l2e_cycle3_valid", 32'(valid_o[2]), 32'h0);
        chk("l2e_cycle3_incr", 32'(incr_o), 32'h0);
        chk("l2e_data_hold", 32'(data_o[2]), 32'hB0A5);

        // Contention on the local output: N, S, W arrive together.
        put(0, 16'h5111, 4, 1);
        put(1, 16'h5222, 4, 1);
        put(3, 16'h5333, 4, 1);
        tick();
        tick();
        chk("cont_first", 32'(data_o[4]), 32'h5111);
        tick();
        chk("cont_second", 32'(data_o[4]), 32'h5222);
        chk("cont_second_valid", 32'(valid_o[4]), 32'h1);
        tick();
        chk("cont_third", 32'(data_o[4]), 32'h5333);
        put(4, 16'h5444, 4, 1);
        put(0, 16'h5555, 4, 1);
        tick();
        tick();
        chk("rr_ptr4_l_first", 32'(data_o[4]), 32'h5444);
        chk("rr_ptr4_incr_l", 32'(incr_o), 32'h10);
        tick();
        chk("rr_ptr4_n_second", 32'(data_o[4]), 32'h5555);
        tick();
        tick();

        // Credit return at full credit, then grant plus return in the same cycle.
        auto_en[2] = 1'b0;
        man_incr[2] = 1'b1;
        tick();
        chk("err_full_credit", 32'(err_o), 32'h04);
        put(4, 16'h8001, 2, 1);
        tick();
        man_incr[2] = 1'b1;
        tick();
        chk("grant_incr_valid", 32'(valid_o[2]), 32'h1);
        tick();
        e0 = emit_cnt[2];
        put(4, 16'h8002, 2, 1);
        tick();
        put(4, 16'h8003, 2, 1);
        tick();
        put(4, 16'h8004, 2, 1);
        tick();
        repeat (4) tick();
        chk("stall_emit_count", 32'(emit_cnt[2] - e0), 32'd2);
        chk("stall_held", 32'(valid_o[2]), 32'h0);
        man_incr[2] = 1'b1;
        tick();
        chk("stall_release_wait", 32'(valid_o[2]), 32'h0);
        tick();
        chk("stall_release_valid", 32'(valid_o[2]), 32'h1);
        chk("stall_release_data", 32'(data_o[2]), 32'h8004);

        // Overflow on N while east has no credit.
        put(0, 16'h8101, 2, 1); tick();
        put(0, 16'h8102, 2, 1); tick();
        put(0, 16'h8103, 2, 1); tick();
        put(0, 16'h8104, 2, 1); tick();
        put(0, 16'h8105, 2, 0); tick();
        chk("ovf_err_o", 32'(err_o), 32'h05);
        tick();
        e0 = emit_cnt[2];
        i0 = incr_cnt[0];
        auto_en[2] = 1'b1;
        man_incr[2] = 1'b1;
        repeat (14) tick();
        chk("ovf_release_count", 32'(emit_cnt[2] - e0), 32'd4);
        chk("ovf_incr_n_count", 32'(incr_cnt[0] - i0), 32'd4);

        // Reset with flits buffered.
        put(0, 16'h8201, 2, 0);
        put(1, 16'h8202, 2, 0);
        put(3, 16'h8203, 2, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid_o", 32'(valid_o), 32'h0);
        chk("rst_err_o", 32'(err_o), 32'h0);
        chk("rst_incr_o", 32'(incr_o), 32'h0);
        chk("rst_data_o_e", 32'(data_o[2]), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_no_valid", 32'(valid_o), 32'h0);
        end

        // Credits restored to DOWN_DEPTH: exactly two west-bound flits pass.
        auto_en[3] = 1'b0;
        e0 = emit_cnt[3];
        put(1, 16'h0301, 3, 1); tick();
        put(1, 16'h0302, 3, 1); tick();
        put(1, 16'h0303, 3, 1); tick();
        repeat (4) tick();
        chk("post_rst_credit_count", 32'(emit_cnt[3] - e0), 32'd2);
        chk("post_rst_err_o", 32'(err_o), 32'h0);
        man_incr[3] = 1'b1;
        tick();
        tick();
        chk("post_rst_release_valid", 32'(valid_o[3]), 32'h1);
        chk("post_rst_release_data", 32'(data_o[3]), 32'h0303);
        repeat (3) tick();
        for (int o = 0; o < 5; o++) chk("sb_drained", 32'(exp_q[o].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
